// File: rtl/uart_pkg.sv
// Shared constants and types for the UART response encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // ASCII characters used in response frames
    localparam logic [7:0] ASCII_EXCL = 8'h21;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_W    = 8'h57;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

    // Encoder control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Frame lengths with the CR LF terminator appended
    localparam logic [3:0] LEN_FAIL_CRLF  = 4'd3;
    localparam logic [3:0] LEN_WRITE_CRLF = 4'd5;
    localparam logic [3:0] LEN_READ_CRLF  = 4'd13;

    // Frame lengths without a terminator
    localparam logic [3:0] LEN_FAIL_RAW   = 4'd1;
    localparam logic [3:0] LEN_WRITE_RAW  = 4'd3;
    localparam logic [3:0] LEN_READ_RAW   = 4'd11;

endpackage

// File: rtl/uart_enc_if.sv
// Request/response and TX byte-stream bundle between core, encoder and serializer.
// Latency: n/a (wires only).
// Backpressure: TX stream is valid/ready; TX_VALID holds until TX_READY.
interface uart_enc_if;

    logic        START;
    logic        STATE_R_IN;
    logic        STATE_W_IN;
    logic        FAIL_IN;
    logic [7:0]  ADDR_IN;
    logic [31:0] DATA_IN;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        BUSY;
    logic        DONE;

    // Encoder side: takes the request, sources the TX byte stream
    modport master (
        input  START, STATE_R_IN, STATE_W_IN, FAIL_IN, ADDR_IN, DATA_IN, TX_READY,
        output TX_DATA, TX_VALID, BUSY, DONE
    );

    // Core/serializer side: issues the request, sinks the TX byte stream
    modport slave (
        output START, STATE_R_IN, STATE_W_IN, FAIL_IN, ADDR_IN, DATA_IN, TX_READY,
        input  TX_DATA, TX_VALID, BUSY, DONE
    );

endinterface

// File: rtl/uart_hex2ascii.sv
// Converts one 4-bit nibble into its uppercase ASCII hex character.
// Latency: combinational.
// Backpressure: none.
module uart_hex2ascii
    import uart_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // '0'..'9' for 0..9, 'A'..'F' for 10..15
    always_comb begin
        if (nibble <= 4'd9) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = ASCII_A + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/uart_enc.sv
// Encodes a R/W/fail response into an ASCII-hex byte frame; UART_ENC_CRLF_EN appends CR LF.
// Latency: first byte registered one cycle after START; DONE one cycle after last byte accepted.
// Backpressure: TX_DATA/TX_VALID held while TX_READY low; START ignored while busy.
module uart_enc
    import uart_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    uart_enc_if.master  bus
);

`ifdef UART_ENC_CRLF_EN
    localparam logic [3:0] LEN_FAIL  = LEN_FAIL_CRLF;
    localparam logic [3:0] LEN_WRITE = LEN_WRITE_CRLF;
    localparam logic [3:0] LEN_READ  = LEN_READ_CRLF;
`else
    localparam logic [3:0] LEN_FAIL  = LEN_FAIL_RAW;
    localparam logic [3:0] LEN_WRITE = LEN_WRITE_RAW;
    localparam logic [3:0] LEN_READ  = LEN_READ_RAW;
`endif

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  len_q, len_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        frm_ok;
    logic [7:0]  frm_hdr;
    logic [3:0]  frm_len;

    logic [3:0]  sel_idx;
    logic [3:0]  nib;
    logic [7:0]  hex_char;
    logic [7:0]  nxt_byte;

    // The byte being prepared is always the one after the byte on the bus
    assign sel_idx = idx_q + 4'd1;

    // Nibble for the next byte: address high/low, then data MSB nibble first
    always_comb begin
        nib = 4'h0;
        case (sel_idx)
            4'd1:    nib = addr_q[7:4];
            4'd2:    nib = addr_q[3:0];
            4'd3:    nib = data_q[31:28];
            4'd4:    nib = data_q[27:24];
            4'd5:    nib = data_q[23:20];
            4'd6:    nib = data_q[19:16];
            4'd7:    nib = data_q[15:12];
            4'd8:    nib = data_q[11:8];
            4'd9:    nib = data_q[7:4];
            4'd10:   nib = data_q[3:0];
            default: nib = 4'h0;
        endcase
    end

    uart_hex2ascii u_hex2ascii (
        .nibble (nib),
        .ascii  (hex_char)
    );

    // Next byte: hex char, or the terminator occupying the last two slots
    always_comb begin
        nxt_byte = hex_char;
`ifdef UART_ENC_CRLF_EN
        if (sel_idx == len_q - 4'd2) begin
            nxt_byte = ASCII_CR;
        end else if (sel_idx == len_q - 4'd1) begin
            nxt_byte = ASCII_LF;
        end
`endif
    end

    // Next-state and datapath: classify in IDLE, stream in SEND, pulse DONE in FIN
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        idx_d      = idx_q;
        len_d      = len_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        frm_ok     = 1'b0;
        frm_hdr    = 8'h00;
        frm_len    = 4'd0;

        // Fail has priority; R and W must be mutually exclusive otherwise
        if (bus.FAIL_IN) begin
            frm_ok  = 1'b1;
            frm_hdr = ASCII_EXCL;
            frm_len = LEN_FAIL;
        end else if (bus.STATE_R_IN && !bus.STATE_W_IN) begin
            frm_ok  = 1'b1;
            frm_hdr = ASCII_R;
            frm_len = LEN_READ;
        end else if (!bus.STATE_R_IN && bus.STATE_W_IN) begin
            frm_ok  = 1'b1;
            frm_hdr = ASCII_W;
            frm_len = LEN_WRITE;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    addr_d = bus.ADDR_IN;
                    data_d = bus.DATA_IN;
                    idx_d  = 4'd0;
                    if (frm_ok) begin
                        len_d      = frm_len;
                        tx_data_d  = frm_hdr;
                        tx_valid_d = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (tx_valid_q && bus.TX_READY) begin
                    if (idx_q == len_q - 4'd1) begin
                        idx_d      = 4'd0;
                        tx_data_d  = 8'h00;
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_FIN;
                    end else begin
                        idx_d     = sel_idx;
                        tx_data_d = nxt_byte;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            addr_q     <= 8'h00;
            data_q     <= 32'h0;
            idx_q      <= 4'd0;
            len_q      <= 4'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.TX_DATA  = tx_data_q;
    assign bus.TX_VALID = tx_valid_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;

endmodule

// File: tb/tb_uart_enc.sv
// Scoreboard bench for uart_enc: stimulus queues expected bytes and DONE cycles,
// a negedge monitor pops and compares on each accepted byte and each DONE pulse.
// Also checks hold-stability under back-pressure and BUSY during frames.
module tb_uart_enc;

`ifdef UART_ENC_CRLF_EN
    localparam int TERM = 2;
`else
    localparam int TERM = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_enc_if bus ();

    uart_enc dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_bytes [$];
    int         exp_done  [$];
    logic [7:0] vec [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic fail_evt(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%0h, required no event (cycle %0d)", name, act, cyc);
    endtask

    // Queue n bytes from vec; full frames also get the terminator and a DONE cycle
    task automatic push_frame(input int n, input int n0, input int stall, input bit full);
        for (int i = 0; i < n; i++) exp_bytes.push_back(vec[i]);
        if (full) begin
`ifdef UART_ENC_CRLF_EN
            exp_bytes.push_back(8'h0D);
            exp_bytes.push_back(8'h0A);
`endif
            exp_done.push_back(n0 + n + TERM + 1 + stall);
        end
    endtask

    // One-cycle START; inputs are scrambled after capture to prove they are buffered
    task automatic start_req(input logic r, input logic w, input logic f,
                             input logic [7:0] a, input logic [31:0] d);
        bus.STATE_R_IN = r;
        bus.STATE_W_IN = w;
        bus.FAIL_IN    = f;
        bus.ADDR_IN    = a;
        bus.DATA_IN    = d;
        bus.START      = 1'b1;
        @(posedge clk);
        #1;
        bus.START      = 1'b0;
        bus.STATE_R_IN = ~r;
        bus.STATE_W_IN = ~w;
        bus.FAIL_IN    = ~f;
        bus.ADDR_IN    = ~a;
        bus.DATA_IN    = ~d;
    endtask

    // Wait until the expected DONE has been seen, bounded
    task automatic wait_frame(input int budget);
        int k;
        k = 0;
        while (exp_done.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (exp_done.size() != 0) begin
            fail_evt("frame_timeout", 32'(exp_done.size()));
            exp_done.delete();
            exp_bytes.delete();
        end
    endtask

    // Monitor: compares accepted bytes and DONE pulses against the queues
    logic [7:0] prev_data  = 8'h00;
    bit         prev_stall = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("stall_valid_hold", 32'(bus.TX_VALID), 32'd1);
                check("stall_data_hold", 32'(bus.TX_DATA), 32'(prev_data));
            end
            prev_stall = bus.TX_VALID && !bus.TX_READY && !rst;
            prev_data  = bus.TX_DATA;
            if (!rst && bus.TX_VALID) begin
                check("busy_in_frame", 32'(bus.BUSY), 32'd1);
                if (bus.TX_READY) begin
                    if (exp_bytes.size() == 0) fail_evt("unexpected_byte", 32'(bus.TX_DATA));
                    else check("tx_byte", 32'(bus.TX_DATA), 32'(exp_bytes.pop_front()));
                end
            end
            if (!rst && bus.DONE) begin
                if (exp_done.size() == 0) begin
                    fail_evt("unexpected_done", 32'(cyc));
                end else begin
                    check("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
                    check("busy_at_done", 32'(bus.BUSY), 32'd0);
                    check("bytes_left_at_done", 32'(exp_bytes.size()), 32'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n0;
        rst            = 1'b1;
        bus.START      = 1'b0;
        bus.STATE_R_IN = 1'b0;
        bus.STATE_W_IN = 1'b0;
        bus.FAIL_IN    = 1'b0;
        bus.ADDR_IN    = 8'h00;
        bus.DATA_IN    = 32'h0;
        bus.TX_READY   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_data", 32'(bus.TX_DATA), 32'h00);
        check("rst_tx_valid", 32'(bus.TX_VALID), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        rst = 1'b0;

        // READ, ADDR=0x3A, DATA=0xDEADBEEF
        vec = '{8'h52, 8'h33, 8'h41, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
        n0 = cyc;
        push_frame(11, n0, 0, 1'b1);
        start_req(1'b1, 1'b0, 1'b0, 8'h3A, 32'hDEADBEEF);
        check("read_first_valid", 32'(bus.TX_VALID), 32'd1);
        check("read_first_busy", 32'(bus.BUSY), 32'd1);
        wait_frame(40);

        // WRITE, ADDR=0x0F
        vec = '{8'h57, 8'h30, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        n0 = cyc;
        push_frame(3, n0, 0, 1'b1);
        start_req(1'b0, 1'b1, 1'b0, 8'h0F, 32'h12345678);
        wait_frame(40);

        // FAIL overrides R: only '!'
        vec = '{8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        n0 = cyc;
        push_frame(1, n0, 0, 1'b1);
        start_req(1'b1, 1'b0, 1'b1, 8'h55, 32'hCAFEF00D);
        wait_frame(40);

        // READ with 3-cycle stall on the 4th byte (0x44)
        vec = '{8'h52, 8'h33, 8'h41, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
        n0 = cyc;
        push_frame(11, n0, 3, 1'b1);
        start_req(1'b1, 1'b0, 1'b0, 8'h3A, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        #1;
        bus.TX_READY = 1'b0;
        check("stall_byte", 32'(bus.TX_DATA), 32'h44);
        repeat (3) @(posedge clk);
        #1;
        bus.TX_READY = 1'b1;
        wait_frame(60);

        // Invalid requests: R=W=1 and R=W=0, no fail
        start_req(1'b1, 1'b1, 1'b0, 8'h12, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("inv11_busy", 32'(bus.BUSY), 32'd0);
        check("inv11_valid", 32'(bus.TX_VALID), 32'd0);
        start_req(1'b0, 1'b0, 1'b0, 8'h34, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("inv00_busy", 32'(bus.BUSY), 32'd0);
        check("inv00_valid", 32'(bus.TX_VALID), 32'd0);

        // START pulsed mid-frame is ignored
        vec = '{8'h57, 8'h30, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        n0 = cyc;
        push_frame(3, n0, 0, 1'b1);
        start_req(1'b0, 1'b1, 1'b0, 8'h0F, 32'h0);
        @(posedge clk);
        #1;
        start_req(1'b0, 1'b0, 1'b1, 8'hAA, 32'h0);
        wait_frame(40);
        repeat (4) @(posedge clk);
        #1;

        // Reset after 5 accepted bytes, then a clean WRITE
        vec = '{8'h52, 8'h33, 8'h41, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
        n0 = cyc;
        push_frame(5, n0, 0, 1'b0);
        start_req(1'b1, 1'b0, 1'b0, 8'h3A, 32'hDEADBEEF);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        check("pre_rst_bytes_left", 32'(exp_bytes.size()), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_valid", 32'(bus.TX_VALID), 32'd0);
        check("midrst_busy", 32'(bus.BUSY), 32'd0);
        check("midrst_done", 32'(bus.DONE), 32'd0);
        check("midrst_data", 32'(bus.TX_DATA), 32'h00);
        rst = 1'b0;
        vec = '{8'h57, 8'h30, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        n0 = cyc;
        push_frame(3, n0, 0, 1'b1);
        start_req(1'b0, 1'b1, 1'b0, 8'h0F, 32'h0);
        wait_frame(40);

        repeat (5) @(posedge clk);
        #1;
        check("end_bytes_queue", 32'(exp_bytes.size()), 32'd0);
        check("end_done_queue", 32'(exp_done.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_enc.md
# uart_enc

- Encoder for UART responses: turns a binary result (R/W/fail flags, 8-bit address, 32-bit data) into an ASCII-hex byte frame for the UART transmitter.
- Uses the same character set as the command decoder: `0`–`9` → 0x30–0x39, `A`–`F` → 0x41–0x46, uppercase only.
- Sits between the register-access core and the UART TX serializer; streams one byte per valid/ready handshake.

## Interface
- No parameters.
- `CLK` in 1: single clock.
- `RST` in 1: reset, synchronous, active-high.
- `START` in 1: one-cycle request; sampled only in IDLE.
- `STATE_R_IN` in 1: read-response flag.
- `STATE_W_IN` in 1: write-acknowledge flag.
- `FAIL_IN` in 1: failure flag; overrides R/W.
- `ADDR_IN` in 8: binary address.
- `DATA_IN` in 32: binary read data.
- `TX_DATA` out 8: current ASCII byte.
- `TX_VALID` out 1: `TX_DATA` is valid.
- `TX_READY` in 1: serializer accepts the byte.
- `BUSY` out 1: high from START acceptance until DONE.
- `DONE` out 1: one-cycle pulse after the last byte is accepted.

## Operation
- **States:** IDLE → SEND → FIN → IDLE.
- **IDLE:**
  - On `START`, capture all inputs into buffers and classify the frame.
  - If the frame is valid, go to SEND. Otherwise ignore the request and stay in IDLE with no `TX_VALID` and no `DONE`.
- **Frame classification, in priority order:**
  - `FAIL_IN`=1 → FAIL frame: 0x21 (`!`).
  - R=1, W=0 → READ frame: 0x52 (`R`), 2 address chars, 8 data chars.
  - R=0, W=1 → WRITE frame: 0x57 (`W`), 2 address chars.
  - R=W (both set or both clear, no fail) → invalid.
- **Character order:** address chars `ADDR[7:4]` then `ADDR[3:0]`; data chars MSB nibble first, `DATA[31:28]` … `DATA[3:0]`.
- **Terminator:** optional CR LF (0x0D 0x0A) per Configuration.
- **SEND:**
  - Byte index counter, 4 bits, runs 0..LEN-1.
  - `TX_DATA` is registered and selected from the index.
  - Index advances only when `TX_VALID` && `TX_READY`.
  - On acceptance of the last byte, go to FIN.
- **FIN:** `DONE`=1 for exactly one cycle, then IDLE.
- **Frame lengths:**
  - CR LF compiled in: FAIL 3, WRITE 5, READ 13.
  - CR LF compiled out: FAIL 1, WRITE 3, READ 11.
- **Other rules:**
  - `START` is ignored in SEND and FIN; there is no queuing.
  - Input changes after capture have no effect on the frame in flight.

## Timing
- Cycle 0 is the edge where `START` is sampled in IDLE.
- `BUSY` rises and the first byte is presented with `TX_VALID`=1 in cycle 1.
- With `TX_READY` tied high, byte k appears in cycle k. `DONE`=1 in cycle LEN+1 and the block is back in IDLE in cycle LEN+2.
- **Back-pressure:** while `TX_VALID`=1 and `TX_READY`=0, `TX_DATA` and `TX_VALID` are held stable. `TX_VALID` never drops mid-frame except on reset.
- `BUSY` falls together with `DONE`.
- **Reset values:** `TX_DATA`=0x00, `TX_VALID`=0, `BUSY`=0, `DONE`=0, state IDLE, buffers and index 0.
- **RST mid-frame:** the frame is abandoned; outputs reach reset values on that edge and no `DONE` is produced.
- **RST together with START:** reset wins.

## Configuration
- Macro: `UART_ENC_CRLF_EN`.
- **Defined:** every frame ends with 0x0D 0x0A; lengths 3/5/13.
- **Undefined:** no terminator; lengths 1/3/11; the last byte is the final hex char (or `!` for FAIL).

## Structure
- **Shared package `uart_pkg`:**
  - ASCII constants: `!`, `R`, `W`, CR, LF, 0x30, 0x41.
  - FSM state typedef.
  - Frame-length constants for both configurations.
- **Sub-module `uart_hex2ascii`:** combinational, 4-bit nibble → 8-bit ASCII.
  - Produces 0x30+n for n ≤ 9 and 0x37+n for n ≥ 10.
  - The encoder uses one instance, fed from a nibble mux driven by the byte index.

## Test plan
- **READ, CR LF on, `TX_READY`=1:** R=1, ADDR=0x3A, DATA=0xDEADBEEF.
  - Required bytes in cycles 1–13: 52 33 41 44 45 41 44 42 45 45 46 0D 0A.
  - `DONE` in cycle 14.
- **WRITE:** W=1, ADDR=0x0F → 57 30 46 0D 0A, then `DONE`.
- **FAIL priority:** FAIL=1, R=1, ADDR=0x55 → 21 0D 0A only; addr/data not sent.
- **Back-pressure:** READ frame with `TX_READY`=0 for 3 cycles while the 4th byte (0x44) is presented.
  - 0x44 held stable with `TX_VALID`=1; the frame completes unchanged.
  - `DONE` 3 cycles later than the no-stall case.
- **Invalid and ignored requests:**
  - R=W=1, FAIL=0 → no `TX_VALID`, no `DONE`, `BUSY` stays 0.
  - `START` pulsed during SEND is ignored.
- **Reset mid-frame:** `RST` after 5 bytes accepted → `TX_VALID`=0, no `DONE`. A following WRITE START produces a complete 57 30 46 0D 0A.
